// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neuron accumulator: activation codes and FSM states.
package tnn_pkg;

    localparam int unsigned PC_W  = 5;
    localparam int unsigned ACT_W = 2;

    localparam logic [ACT_W-1:0] ACT_POS  = 2'b01;
    localparam logic [ACT_W-1:0] ACT_NEG  = 2'b11;
    localparam logic [ACT_W-1:0] ACT_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } tnn_state_e;

endpackage : tnn_pkg

// File: rtl/ternary_neuron_acc_if.sv
// Beat-in / result-out handshake bundle for ternary_neuron_acc.
interface ternary_neuron_acc_if #(
    parameter int unsigned ACC_W = 10
);
    import tnn_pkg::*;

    logic [PC_W-1:0]  pc_pos;
    logic [PC_W-1:0]  pc_neg;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACT_W-1:0] act;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    modport master (
        output pc_pos, pc_neg, in_valid, in_last, out_ready,
        input  in_ready, out_valid, act, sum, ovf
    );

    modport slave (
        input  pc_pos, pc_neg, in_valid, in_last, out_ready,
        output in_ready, out_valid, act, sum, ovf
    );

endinterface : ternary_neuron_acc_if

// File: rtl/tnn_sat_addsub.sv
// Saturating signed base + zext(add_val) - zext(sub_val); clip flags a clamped result.
module tnn_sat_addsub
    import tnn_pkg::*;
#(
    parameter int unsigned ACC_W = 10
) (
    input  logic signed [ACC_W-1:0] base,
    input  logic        [PC_W-1:0]  add_val,
    input  logic        [PC_W-1:0]  sub_val,
    output logic signed [ACC_W-1:0] res,
    output logic                    clip
);

    // Two guard bits are enough: |add - sub| <= 31 and ACC_W >= 6.
    localparam int unsigned WIDE_W = ACC_W + 2;

    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;

    always_comb begin
        max_v = WIDE_W'({1'b0, {(ACC_W-1){1'b1}}});
        min_v = ~max_v;
        wide  = WIDE_W'(base) + WIDE_W'(add_val) - WIDE_W'(sub_val);
        clip  = 1'b0;
        res   = ACC_W'(wide);
        if (wide > max_v) begin
            res  = ACC_W'(max_v);
            clip = 1'b1;
        end else if (wide < min_v) begin
            res  = ACC_W'(min_v);
            clip = 1'b1;
        end
    end

endmodule : tnn_sat_addsub

// File: rtl/ternary_neuron_acc.sv
// Ternary neuron: accumulates popcount beats into a saturating sum, then thresholds to -1/0/+1.
module ternary_neuron_acc
    import tnn_pkg::*;
#(
    parameter int unsigned ACC_W     = 10,
    parameter int unsigned MAX_BEATS = 16,
    parameter int          THR_HI    = 3,
    parameter int          THR_LO    = -3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pc_pos,
    input  logic [PC_W-1:0]  pc_neg,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACT_W-1:0] act,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    tnn_state_e              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic [ACC_W-1:0]        sum_q, sum_d;
    logic [ACT_W-1:0]        act_q, act_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_clip;
    logic                    accept;
    logic                    forced;
    logic                    last_eff;
    logic [ACT_W-1:0]        act_res;

    // A fresh evaluation starts from zero rather than the stale accumulator.
    assign base = (state_q == ST_ACC) ? acc_q : '0;

    tnn_sat_addsub #(.ACC_W(ACC_W)) u_addsub (
        .base    (base),
        .add_val (pc_pos),
        .sub_val (pc_neg),
        .res     (add_res),
        .clip    (add_clip)
    );

    always_comb begin
        accept   = in_valid && in_ready_q;
        forced   = accept && !in_last && (cnt_q == CNT_W'(MAX_BEATS - 1));
        last_eff = in_last || forced;

        if ($signed(add_res) >= THR_HI) begin
            act_res = ACT_POS;
        end else if ($signed(add_res) <= THR_LO) begin
            act_res = ACT_NEG;
        end else begin
            act_res = ACT_ZERO;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        sum_d       = sum_q;
        act_d       = act_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    acc_d = add_res;
                    cnt_d = cnt_q + CNT_W'(1);
                    sat_d = sat_q || add_clip;
                    if (last_eff) begin
                        state_d     = ST_DONE;
                        sum_d       = ACC_W'(add_res);
                        act_d       = act_res;
                        ovf_d       = sat_q || add_clip || forced;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            sum_q       <= '0;
            act_q       <= ACT_ZERO;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            sum_q       <= sum_d;
            act_q       <= act_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign act       = act_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule : ternary_neuron_acc

// File: tb/tb_ternary_neuron_acc.sv
// Directed self-checking bench for ternary_neuron_acc (default and ACC_W=8 instances).
module tb_ternary_neuron_acc;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    ternary_neuron_acc_if #(.ACC_W(10)) bus ();

    logic       in_ready8;
    logic       out_valid8;
    logic [1:0] act8;
    logic [7:0] sum8;
    logic       ovf8;

    ternary_neuron_acc u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_pos    (bus.pc_pos),
        .pc_neg    (bus.pc_neg),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .act       (bus.act),
        .sum       (bus.sum),
        .ovf       (bus.ovf)
    );

    ternary_neuron_acc #(.ACC_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_pos    (bus.pc_pos),
        .pc_neg    (bus.pc_neg),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .in_ready  (in_ready8),
        .out_valid (out_valid8),
        .out_ready (bus.out_ready),
        .act       (act8),
        .sum       (sum8),
        .ovf       (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] s10(input int v);
        logic [9:0] t;
        t = 10'(v);
        return {22'b0, t};
    endfunction

    function automatic logic [31:0] s8(input int v);
        logic [7:0] t;
        t = 8'(v);
        return {24'b0, t};
    endfunction

    task automatic send(input int p, input int n, input logic l);
        bus.pc_pos   = 5'(p);
        bus.pc_neg   = 5'(n);
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic single(input string tag, input int p, input int n, input int exp_sum,
                          input logic [1:0] exp_act);
        send(p, n, 1'b1);
        chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, {22'b0, bus.sum}, s10(exp_sum));
        chk({tag, "_act"}, 32'(bus.act), 32'(exp_act));
        handshake(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pc_pos    = '0;
        bus.pc_neg    = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", {22'b0, bus.sum}, 32'd0);
        chk("rst_act", 32'(bus.act), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);

        // single beat 10-2 = 8
        send(10, 2, 1'b1);
        chk("one_ov", 32'(bus.out_valid), 32'd1);
        chk("one_sum", {22'b0, bus.sum}, s10(8));
        chk("one_act", 32'(bus.act), 32'd1);
        chk("one_ovf", 32'(bus.ovf), 32'd0);
        chk("one_rdy", 32'(bus.in_ready), 32'd0);
        handshake("one");

        // three beats: 0 - 3 - 2 = -5, held while out_ready low
        send(5, 5, 1'b0);
        send(1, 4, 1'b0);
        chk("three_mid_ov", 32'(bus.out_valid), 32'd0);
        send(0, 2, 1'b1);
        chk("three_ov", 32'(bus.out_valid), 32'd1);
        chk("three_sum", {22'b0, bus.sum}, s10(-5));
        chk("three_act", 32'(bus.act), 32'h3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("three_hold_ov", 32'(bus.out_valid), 32'd1);
            chk("three_hold_sum", {22'b0, bus.sum}, s10(-5));
            chk("three_hold_act", 32'(bus.act), 32'h3);
        end
        handshake("three");

        // threshold boundaries
        single("thr_p3", 3, 0, 3, 2'b01);
        single("thr_m3", 0, 3, -3, 2'b11);
        single("thr_p2", 2, 0, 2, 2'b00);
        single("thr_m2", 0, 2, -2, 2'b00);

        // 16 beats of 31 without in_last: forced termination
        for (int i = 0; i < 15; i++) send(31, 0, 1'b0);
        chk("force_pre_ov", 32'(bus.out_valid), 32'd0);
        send(31, 0, 1'b0);
        chk("force_ov", 32'(bus.out_valid), 32'd1);
        chk("force_sum", {22'b0, bus.sum}, s10(496));
        chk("force_ovf", 32'(bus.ovf), 32'd1);
        chk("force_act", 32'(bus.act), 32'd1);
        chk("force8_ov", 32'(out_valid8), 32'd1);
        chk("force8_sum", {24'b0, sum8}, s8(127));
        chk("force8_ovf", 32'(ovf8), 32'd1);
        handshake("force");

        // reset mid-evaluation discards partial sum
        send(5, 0, 1'b0);
        send(5, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ov", 32'(bus.out_valid), 32'd0);
        chk("mrst_sum", {22'b0, bus.sum}, 32'd0);
        chk("mrst_ovf", 32'(bus.ovf), 32'd0);
        chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        single("mrst_fresh", 4, 0, 4, 2'b01);

        // back-to-back with in_valid held high across DONE
        bus.in_valid = 1'b1;
        bus.pc_pos   = 5'd1;
        bus.pc_neg   = 5'd0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        bus.pc_pos  = 5'd2;
        bus.in_last = 1'b1;
        @(negedge clk);
        chk("b2b_ov", 32'(bus.out_valid), 32'd1);
        chk("b2b_sum", {22'b0, bus.sum}, s10(3));
        chk("b2b_rdy", 32'(bus.in_ready), 32'd0);
        bus.pc_pos    = 5'd7;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("b2b_hs_ov", 32'(bus.out_valid), 32'd0);
        chk("b2b_hs_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("b2b2_ov", 32'(bus.out_valid), 32'd1);
        chk("b2b2_sum", {22'b0, bus.sum}, s10(7));
        chk("b2b2_ovf", 32'(bus.ovf), 32'd0);
        handshake("b2b2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ternary_neuron_acc

// File: doc/ternary_neuron_acc.md
TERNARY_NEURON_ACC -- requirements
Module: ternary_neuron_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 10, meaning signed accumulator width in bits.
REQ-002 SHALL have parameter MAX_BEATS, default 16, meaning the largest number of beats in one neuron evaluation.
REQ-003 SHALL have parameter THR_HI, default 3, meaning the signed threshold at or above which the activation is +1.
REQ-004 SHALL have parameter THR_LO, default -3, meaning the signed threshold at or below which the activation is -1; THR_LO < THR_HI always holds.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pc_pos, input, 5 bits: unsigned popcount21 result for +1-weight inputs.
REQ-008 SHALL have port pc_neg, input, 5 bits: unsigned popcount21 result for -1-weight inputs.
REQ-009 SHALL have port in_valid, input, 1 bit: the beat on pc_pos/pc_neg is valid.
REQ-010 SHALL have port in_last, input, 1 bit: the current beat is the final beat of the evaluation.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port act, output, 2 bits: ternary activation, 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
REQ-015 SHALL have port sum, output, ACC_W bits: signed final accumulator value.
REQ-016 SHALL have port ovf, output, 1 bit: the evaluation saturated or was force-terminated.

Function
REQ-017 SHALL implement FSM states IDLE, ACC and DONE.
REQ-018 SHALL drive in_ready = 1 in IDLE and ACC, and 0 in DONE.
REQ-019 SHALL treat a beat as accepted only when in_valid && in_ready.
REQ-020 SHALL compute, per accepted beat, acc_next = base + zext(pc_pos) - zext(pc_neg), where base = 0 in IDLE and base = acc in ACC.
REQ-021 SHALL saturate acc_next to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1] and set a sticky sat flag when clipping occurs.
REQ-022 SHALL treat the pc inputs as full 0..31 values, with no clamping to 21.
REQ-023 SHALL hold a beat counter that increments per accepted beat.
REQ-024 SHALL force the current beat to be treated as last when it is the MAX_BEATS-th beat and in_last = 0, and set ovf.
REQ-025 SHALL make the transition IDLE->ACC on an accepted non-last beat.
REQ-026 SHALL make the transition IDLE/ACC->DONE on an accepted last or forced-last beat.
REQ-027 SHALL stay in ACC with no change when in_valid = 0.
REQ-028 SHALL, on entry to DONE, register sum, act and ovf, with ovf = sat || forced; out_valid rises the cycle after the last beat (latency 1).
REQ-029 SHALL set act = +1 if sum >= THR_HI, act = -1 if sum <= THR_LO, and act = 0 otherwise.
REQ-030 SHALL hold out_valid, act, sum and ovf stable in DONE until out_ready = 1.
REQ-031 SHALL make the transition DONE->IDLE when out_valid && out_ready, clearing acc, the counter, sat and out_valid on that edge.
REQ-032 SHALL accept no new beat in the cycle of the output handshake, since in_ready = 0 in DONE.
REQ-033 SHALL complete a single-beat evaluation (in_last = 1 in IDLE) directly IDLE->DONE.

Reset
REQ-034 SHALL, when rst_n = 0, asynchronously force state IDLE and acc, counter, sat, sum, act and ovf to 0, and out_valid to 0.
REQ-035 SHALL give in_ready the value 1 after reset release.
REQ-036 SHALL discard any partial evaluation when reset is asserted mid-evaluation, with no output produced.

Structure
REQ-037 SHALL place the act encodings (ACT_POS, ACT_NEG, ACT_ZERO) and the FSM state enum in shared package tnn_pkg.
REQ-038 SHALL implement the saturating signed add-subtract as sub-module tnn_sat_addsub, parameterised by ACC_W.
REQ-039 SHALL instantiate no popcount logic; pc_pos and pc_neg come from upstream popcount21 instances.

Verification
REQ-040 SHALL cover: single beat pc_pos=10, pc_neg=2, in_last=1 -> next cycle out_valid=1, sum=8, act=01, ovf=0.
REQ-041 SHALL cover: 3 beats (5,5), (1,4), (0,2), last on 3rd -> sum=-5, act=11; held over 4 cycles of out_ready=0, then cleared after the handshake.
REQ-042 SHALL cover: sums of exactly 3 and -3 each give ±1; sums of 2 and -2 give act=00.
REQ-043 SHALL cover: 16 beats of (31,0) with in_last never set -> on the 16th beat, forced DONE, sum=496, ovf=1; with ACC_W=8, sum=127, ovf=1.
REQ-044 SHALL cover: rst_n pulsed low after 2 of 4 beats -> outputs 0, in_ready=1; a fresh single beat (4,0) then gives sum=4 with no carry-over.
REQ-045 SHALL cover: in_valid held high with back-to-back evaluations -> in_ready=0 during DONE, and no beat is lost or double-counted across the boundary.
